// File: rtl/ctrl_from_network_bridge_splitter.sv
// Control-message demultiplexer: ingress AXIS from the network bridge is
// routed per beat to the NAC (READ/WRITE) or to the ANC (responses).
//
// Ports:
//   i_clk, i_ap_rst_n               clock, async active-low reset
//   from_network_bridge_*           ingress AXIS (tvalid/tready/tdata/
//                                   tkeep/tid/tdest/tuser/tlast)
//   to_nac_*                        request egress (READ, WRITE)
//   to_anc_*                        response egress (RDATA, BRESP, BUSY, ...)
//
// Optional feature, macro CTRL_SPLIT_DROP_UNKNOWN_EN:
//   defined   - codes other than READ/WRITE/RDATA/BRESP/BUSY are accepted
//               and discarded (tready=1, no egress valid)
//   undefined - unknown codes go to the ANC like any response
//
// The path is purely combinational. The clock only samples an internal
// protocol assertion.

module ctrl_from_network_bridge_splitter #(
    parameter int AXIS_DATA_WIDTH          = 128,
    parameter int AXIS_KEEP_WIDTH          = 16,
    parameter int AXIS_FROM_NB_TDEST_WIDTH = 8,
    parameter int AXIS_FROM_NB_TUSER_WIDTH = 32,
    parameter int AXIS_MSG_TYPE_WIDTH      = 4,
    parameter int MSG_READ                 = 0,
    parameter int MSG_WRITE                = 1,
    parameter int MSG_RDATA                = 2,
    parameter int MSG_BRESP                = 3,
    parameter int MSG_BUSY                 = 4
) (
    input  logic                                i_clk,
    input  logic                                i_ap_rst_n,

    input  logic                                from_network_bridge_tvalid,
    output logic                                from_network_bridge_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]          from_network_bridge_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]          from_network_bridge_tkeep,
    input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] from_network_bridge_tid,
    input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] from_network_bridge_tdest,
    input  logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] from_network_bridge_tuser,
    input  logic                                from_network_bridge_tlast,

    output logic                                to_anc_tvalid,
    input  logic                                to_anc_tready,
    output logic [AXIS_DATA_WIDTH-1:0]          to_anc_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]          to_anc_tkeep,
    output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_anc_tid,
    output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_anc_tdest,
    output logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] to_anc_tuser,
    output logic                                to_anc_tlast,

    output logic                                to_nac_tvalid,
    input  logic                                to_nac_tready,
    output logic [AXIS_DATA_WIDTH-1:0]          to_nac_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]          to_nac_tkeep,
    output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_nac_tid,
    output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_nac_tdest,
    output logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] to_nac_tuser,
    output logic                                to_nac_tlast
);

    localparam logic [AXIS_MSG_TYPE_WIDTH-1:0] T_READ  =
        AXIS_MSG_TYPE_WIDTH'(MSG_READ);
    localparam logic [AXIS_MSG_TYPE_WIDTH-1:0] T_WRITE =
        AXIS_MSG_TYPE_WIDTH'(MSG_WRITE);

    logic [AXIS_MSG_TYPE_WIDTH-1:0] msg_type;
    logic                           is_req;
    logic                           is_rsp;
    logic                           rsp_ready;

    // Same type field position for LAN and KIP message formats.
    assign msg_type = from_network_bridge_tdata[AXIS_MSG_TYPE_WIDTH-1:0];
    assign is_req   = (msg_type == T_READ) || (msg_type == T_WRITE);

`ifdef CTRL_SPLIT_DROP_UNKNOWN_EN
    localparam logic [AXIS_MSG_TYPE_WIDTH-1:0] T_RDATA =
        AXIS_MSG_TYPE_WIDTH'(MSG_RDATA);
    localparam logic [AXIS_MSG_TYPE_WIDTH-1:0] T_BRESP =
        AXIS_MSG_TYPE_WIDTH'(MSG_BRESP);
    localparam logic [AXIS_MSG_TYPE_WIDTH-1:0] T_BUSY  =
        AXIS_MSG_TYPE_WIDTH'(MSG_BUSY);

    logic is_known_rsp;

    assign is_known_rsp = (msg_type == T_RDATA) ||
                          (msg_type == T_BRESP) ||
                          (msg_type == T_BUSY);
    // Unknown codes are sunk: always ready, never forwarded.
    assign is_rsp    = is_known_rsp;
    assign rsp_ready = is_known_rsp ? to_anc_tready : 1'b1;
`else
    assign is_rsp    = ~is_req;
    assign rsp_ready = to_anc_tready;
`endif

    // tvalid in the AND keeps valids at 0 when the type field is X
    // while idle.
    assign to_nac_tvalid = from_network_bridge_tvalid & is_req & i_ap_rst_n;
    assign to_anc_tvalid = from_network_bridge_tvalid & is_rsp & i_ap_rst_n;

    // Ready is independent of tvalid; the unselected tready is ignored.
    assign from_network_bridge_tready =
        i_ap_rst_n & (is_req ? to_nac_tready : rsp_ready);

    // Payload is broadcast; each consumer qualifies it with its tvalid.
    assign to_anc_tdata = from_network_bridge_tdata;
    assign to_anc_tkeep = from_network_bridge_tkeep;
    assign to_anc_tid   = from_network_bridge_tid;
    assign to_anc_tdest = from_network_bridge_tdest;
    assign to_anc_tuser = from_network_bridge_tuser;
    assign to_anc_tlast = from_network_bridge_tlast;

    assign to_nac_tdata = from_network_bridge_tdata;
    assign to_nac_tkeep = from_network_bridge_tkeep;
    assign to_nac_tid   = from_network_bridge_tid;
    assign to_nac_tdest = from_network_bridge_tdest;
    assign to_nac_tuser = from_network_bridge_tuser;
    assign to_nac_tlast = from_network_bridge_tlast;

    // A beat must never be offered to both consumers at once.
    a_one_egress : assert property (
        @(posedge i_clk) disable iff (!i_ap_rst_n)
        !(to_nac_tvalid && to_anc_tvalid)
    );

endmodule

// File: tb/tb_ctrl_from_network_bridge_splitter.sv
// Directed self-checking bench for ctrl_from_network_bridge_splitter.
// Expected values are hand-derived per test vector.

module tb_ctrl_from_network_bridge_splitter;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [15:0]  in_keep;
    logic [7:0]   in_id;
    logic [7:0]   in_dest;
    logic [31:0]  in_user;
    logic         in_last;

    logic         anc_valid;
    logic         anc_ready;
    logic [127:0] anc_data;
    logic [15:0]  anc_keep;
    logic [7:0]   anc_id;
    logic [7:0]   anc_dest;
    logic [31:0]  anc_user;
    logic         anc_last;

    logic         nac_valid;
    logic         nac_ready;
    logic [127:0] nac_data;
    logic [15:0]  nac_keep;
    logic [7:0]   nac_id;
    logic [7:0]   nac_dest;
    logic [31:0]  nac_user;
    logic         nac_last;

    int vectors;
    int miscompares;

`ifdef CTRL_SPLIT_DROP_UNKNOWN_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    ctrl_from_network_bridge_splitter dut (
        .i_clk                      (clk),
        .i_ap_rst_n                 (rst_n),
        .from_network_bridge_tvalid (in_valid),
        .from_network_bridge_tready (in_ready),
        .from_network_bridge_tdata  (in_data),
        .from_network_bridge_tkeep  (in_keep),
        .from_network_bridge_tid    (in_id),
        .from_network_bridge_tdest  (in_dest),
        .from_network_bridge_tuser  (in_user),
        .from_network_bridge_tlast  (in_last),
        .to_anc_tvalid              (anc_valid),
        .to_anc_tready              (anc_ready),
        .to_anc_tdata               (anc_data),
        .to_anc_tkeep               (anc_keep),
        .to_anc_tid                 (anc_id),
        .to_anc_tdest               (anc_dest),
        .to_anc_tuser               (anc_user),
        .to_anc_tlast               (anc_last),
        .to_nac_tvalid              (nac_valid),
        .to_nac_tready              (nac_ready),
        .to_nac_tdata               (nac_data),
        .to_nac_tkeep               (nac_keep),
        .to_nac_tid                 (nac_id),
        .to_nac_tdest               (nac_dest),
        .to_nac_tuser               (nac_user),
        .to_nac_tlast               (nac_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a beat and let it settle away from the clock edge.
    task automatic drive(input logic [127:0] d, input logic [15:0] k,
                         input logic [7:0] id, input logic [7:0] dst,
                         input logic [31:0] u, input logic l,
                         input logic ar, input logic nr);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_keep   = k;
        in_id     = id;
        in_dest   = dst;
        in_user   = u;
        in_last   = l;
        anc_ready = ar;
        nac_ready = nr;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 128'h4;
        anc_ready = 1'b1;
        nac_ready = 1'b1;
        #1;
        vectors++;
        if ({anc_valid, nac_valid, in_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_idle: got %b want 000",
                     {anc_valid, nac_valid, in_ready});
        end
        // X type field with tvalid low must not leak X onto valids.
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_data  = 'x;
        #1;
        vectors++;
        if ({anc_valid, nac_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL x_type_idle: got %b want 00",
                     {anc_valid, nac_valid});
        end
    endtask

    task automatic test_busy;
        drive(128'h4, 16'hFFFF, 8'hEE, 8'h01, 32'hAAAABBBB, 1'b0,
              1'b1, 1'b0);
        vectors++;
        if ({anc_valid, in_ready, nac_valid} !== 3'b110) begin
            miscompares++;
            $display("FAIL busy_route: got %b want 110",
                     {anc_valid, in_ready, nac_valid});
        end
        vectors++;
        if (anc_user !== 32'hAAAABBBB || anc_id !== 8'hEE ||
            anc_last !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_side: got %h/%h/%b want aaaabbbb/ee/0",
                     anc_user, anc_id, anc_last);
        end
        anc_ready = 1'b0;
        nac_ready = 1'b1;
        #1;
        vectors++;
        if ({anc_valid, in_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL busy_ready: got %b want 10",
                     {anc_valid, in_ready});
        end
    endtask

    task automatic test_write;
        logic [127:0] d;
        d = {32'hCECECECE, 56'h3ABABABABABABA, 4'hB, 32'h0, 4'h1};
        drive(d, 16'hFFFF, 8'hFE, 8'h02, 32'h1234, 1'b1, 1'b1, 1'b0);
        vectors++;
        if ({nac_valid, anc_valid, in_ready} !== 3'b100) begin
            miscompares++;
            $display("FAIL write_route: got %b want 100",
                     {nac_valid, anc_valid, in_ready});
        end
        anc_ready = 1'b0;
        nac_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL write_ready: got %b want 1", in_ready);
        end
        vectors++;
        if (nac_data !== d || nac_id !== 8'hFE || nac_dest !== 8'h02 ||
            nac_last !== 1'b1) begin
            miscompares++;
            $display("FAIL write_data: got %h/%h/%h/%b want %h/fe/02/1",
                     nac_data, nac_id, nac_dest, nac_last, d);
        end
    endtask

    task automatic test_bresp;
        drive(128'h3, 16'h000F, 8'hCD, 8'h03, 32'hBBBBCCCC, 1'b1,
              1'b1, 1'b0);
        vectors++;
        if ({anc_valid, nac_valid, in_ready} !== 3'b101 ||
            anc_user !== 32'hBBBBCCCC || anc_id !== 8'hCD) begin
            miscompares++;
            $display("FAIL bresp_route: got %b %h %h want 101 bbbbcccc cd",
                     {anc_valid, nac_valid, in_ready}, anc_user, anc_id);
        end
        anc_ready = 1'b0;
        nac_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bresp_ready: got %b want 0", in_ready);
        end
    endtask

    task automatic test_back_to_back;
        drive({56'h2BABABABABABAB, 68'h0, 4'h0}, 16'h000D, 8'h11,
              8'h04, 32'h0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if ({nac_valid, anc_valid, in_ready} !== 3'b101 ||
            nac_keep !== 16'h000D) begin
            miscompares++;
            $display("FAIL read_route: got %b keep %h want 101 keep 000d",
                     {nac_valid, anc_valid, in_ready}, nac_keep);
        end
        // Next beat, previous tlast=0: must still be re-decoded.
        drive({32'hADADADAD, 92'h0, 4'h2}, 16'hFFFF, 8'hAB, 8'h05,
              32'h0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if ({anc_valid, nac_valid, in_ready} !== 3'b101 ||
            anc_id !== 8'hAB || anc_data[127:96] !== 32'hADADADAD) begin
            miscompares++;
            $display("FAIL rdata_route: got %b %h %h want 101 ab adadadad",
                     {anc_valid, nac_valid, in_ready}, anc_id,
                     anc_data[127:96]);
        end
    endtask

    task automatic test_reset_midtransfer;
        logic [127:0] d;
        d = 128'hABCD_0001;
        drive(d, 16'hFFFF, 8'h22, 8'h06, 32'h5, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({anc_valid, nac_valid, in_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_mid: got %b want 000",
                     {anc_valid, nac_valid, in_ready});
        end
        vectors++;
        if (nac_data !== d || anc_data !== d) begin
            miscompares++;
            $display("FAIL rst_pass: got %h/%h want %h",
                     nac_data, anc_data, d);
        end
        #3;
        rst_n = 1'b1;
        #1;
        vectors++;
        if ({anc_valid, nac_valid, in_ready} !== 3'b011) begin
            miscompares++;
            $display("FAIL rst_recover: got %b want 011",
                     {anc_valid, nac_valid, in_ready});
        end
    endtask

    task automatic test_unknown;
        drive(128'hF, 16'hFFFF, 8'h33, 8'h07, 32'h0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (DROP) begin
            if ({anc_valid, nac_valid, in_ready} !== 3'b001) begin
                miscompares++;
                $display("FAIL unknown_drop: got %b want 001",
                         {anc_valid, nac_valid, in_ready});
            end
        end else begin
            if ({anc_valid, nac_valid, in_ready} !== 3'b100) begin
                miscompares++;
                $display("FAIL unknown_anc: got %b want 100",
                         {anc_valid, nac_valid, in_ready});
            end
        end
    endtask

    // Every type code, both ready polarities.
    task automatic test_all_codes;
        logic       req;
        logic       rsp;
        logic       sink;
        logic [2:0] exp;
        for (int c = 0; c < 16; c++) begin
            req  = (c < 2);
            sink = DROP && (c > 4);
            rsp  = !req && !sink;
            drive({124'h5A5A_0000_1111_2222_3333_4444_5555_666, 4'(c)},
                  16'hFFFF, 8'(c), 8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
            exp = {nac_valid, anc_valid, in_ready};
            vectors++;
            if (exp !== {req, rsp, req | sink}) begin
                miscompares++;
                $display("FAIL code%0d_nr: got %b want %b", c, exp,
                         {req, rsp, req | sink});
            end
            anc_ready = 1'b1;
            nac_ready = 1'b0;
            #1;
            vectors++;
            if (in_ready !== !req) begin
                miscompares++;
                $display("FAIL code%0d_ar: got %b want %b", c,
                         in_ready, !req);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_keep     = '0;
        in_id       = '0;
        in_dest     = '0;
        in_user     = '0;
        in_last     = 1'b0;
        anc_ready   = 1'b0;
        nac_ready   = 1'b0;
        repeat (2) @(posedge clk);
        test_reset;
        test_busy;
        test_write;
        test_bresp;
        test_back_to_back;
        test_reset_midtransfer;
        test_unknown;
        test_all_codes;
        @(negedge clk);
        in_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
